inv_substitutebytes_seq: RTL and testbench

- Sequential AES InvSubBytes engine. Applies the inverse S-box to all 16 bytes of a 128-bit state or round-key block.
- Time-multiplexes BPC inverse-S-box lookups over 16/BPC cycles.
- Sits in the decryption datapath as the inverse counterpart of the key/state byte-substitution stage.
- Valid/ready handshake on both sides, so it can be stalled by the round controller.

---
 rtl/inv_substitutebytes_seq.sv | 160 ++++++++++++++++
 tb/tb_inv_substitutebytes_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_substitutebytes_seq.sv
// Sequential AES InvSubBytes engine: BPC inverse-S-box lanes sweep a 128-bit block in 16/BPC cycles.
// Optional INVSUB_FWD_MODE_EN adds a per-block mode input selecting the forward S-box instead.
module inv_substitutebytes_seq #(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INVSUB_FWD_MODE_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bpc_check
    $error("inv_substitutebytes_seq: BPC must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

`ifdef INVSUB_FWD_MODE_EN
  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [127:0]     blk_q, blk_nx, run_blk;
  logic [BPC*8-1:0] cur_slice, sub_slice;
`ifdef INVSUB_FWD_MODE_EN
  logic             mode_q, mode_nx;
`endif

  // Slice currently addressed by the byte counter.
  always_comb begin
    cur_slice = '0;
    for (int s = 0; s < N; s++)
      if (cnt == CW'(s)) cur_slice = blk_q[s*BPC*8 +: BPC*8];
  end

  for (genvar l = 0; l < BPC; l++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_in = cur_slice[l*8 +: 8];
`ifdef INVSUB_FWD_MODE_EN
    assign sub_slice[l*8 +: 8] = mode_q ? FWD_SBOX[lane_in] : INV_SBOX[lane_in];
`else
    assign sub_slice[l*8 +: 8] = INV_SBOX[lane_in];
`endif
  end

  always_comb begin
    run_blk = blk_q;
    for (int s = 0; s < N; s++)
      if (cnt == CW'(s)) run_blk[s*BPC*8 +: BPC*8] = sub_slice;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    blk_nx   = blk_q;
`ifdef INVSUB_FWD_MODE_EN
    mode_nx  = mode_q;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          blk_nx   = in_data;
          cnt_nx   = '0;
          state_nx = RUN;
`ifdef INVSUB_FWD_MODE_EN
          mode_nx  = mode;
`endif
        end
      end
      RUN: begin
        blk_nx = run_blk;
        if (cnt == CW'(N - 1)) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      // NOTE: the block buffer is a plain register (not a RAM) and is reset so out_data reads zero after reset.
      blk_q  <= '0;
`ifdef INVSUB_FWD_MODE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_nx;
      cnt    <= cnt_nx;
      blk_q  <= blk_nx;
`ifdef INVSUB_FWD_MODE_EN
      mode_q <= mode_nx;
`endif
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_data  = blk_q;

endmodule

// File: tb/tb_inv_substitutebytes_seq.sv
// Bench for inv_substitutebytes_seq: three instances (BPC 1, 4, 16) checked against a GF(2^8) model.
// With INVSUB_FWD_MODE_EN defined the forward/inverse round trip is exercised as well.
module tb_inv_substitutebytes_seq;

  localparam int NU = 3;
  localparam int NV = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [NU];
  logic         in_ready  [NU];
  logic [127:0] in_data   [NU];
  logic         out_valid [NU];
  logic         out_ready [NU];
  logic [127:0] out_data  [NU];
  logic         busy      [NU];
`ifdef INVSUB_FWD_MODE_EN
  logic         mode      [NU];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int B = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    inv_substitutebytes_seq #(.BPC(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
`ifdef INVSUB_FWD_MODE_EN
      .mode      (mode[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic int n_of(input int u);
    return (u == 0) ? 16 : (u == 1) ? 4 : 1;
  endfunction

  // Reference model: S-box derived from GF(2^8) inversion plus the AES affine map.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    s = r ^ 8'h63;
    for (int i = 0; i < 4; i++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s;
  endfunction

  function automatic logic [127:0] inv_block(input logic [127:0] d);
    logic [127:0] q;
    for (int k = 0; k < 16; k++) q[8*k +: 8] = inv_tab[d[8*k +: 8]];
    return q;
  endfunction

  function automatic logic [127:0] fwd_block(input logic [127:0] d);
    logic [127:0] q;
    for (int k = 0; k < 16; k++) q[8*k +: 8] = fwd_tab[d[8*k +: 8]];
    return q;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic run_block(input int u, input logic [127:0] d, input logic md, input logic keep_ready,
                           output logic [127:0] q, output int lat);
    int w;
    w = 0;
    while (!in_ready[u] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", in_ready[u], 1'b1);
    in_data[u]  = d;
    in_valid[u] = 1'b1;
`ifdef INVSUB_FWD_MODE_EN
    mode[u]     = md;
`endif
    out_ready[u] = keep_ready;
    @(negedge clk);
    in_valid[u] = 1'b0;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q = out_data[u];
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [127:0] q, d, d2, exp;
    int           lat;
    logic         seen;

    for (int u = 0; u < NU; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b0; in_data[u] = '0;
`ifdef INVSUB_FWD_MODE_EN
      mode[u] = 1'b0;
`endif
    end

    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_math(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    vecs[0] = '{128'h63636363_63636363_636363ED_00167C63, 128'h00000000_00000000_00000053_52FF0100};
    vecs[1] = '{128'h0, {16{8'h52}}};
    vecs[2] = '{{16{8'hFF}}, {16{8'h7D}}};
    for (int i = 3; i < NV; i++) begin
      vecs[i].din  = rand128();
      vecs[i].dout = inv_block(vecs[i].din);
    end

    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++)
      check($sformatf("reset_low_u%0d", u), {in_ready[u], out_valid[u], busy[u], out_data[u]}, {3'b100, 128'h0});
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < NU; u++)
      check($sformatf("reset_rel_u%0d", u), {in_ready[u], out_valid[u], busy[u], out_data[u]}, {3'b100, 128'h0});

    // Table-driven vectors on every instance; odd rows hold out_ready high throughout
    for (int i = 0; i < NV; i++)
      for (int u = 0; u < NU; u++) begin
        run_block(u, vecs[i].din, 1'b0, (i % 2) == 1, q, lat);
        check($sformatf("vec%0d_u%0d_data", i, u), q, vecs[i].dout);
        check($sformatf("vec%0d_u%0d_lat", i, u), lat, n_of(u));
        check($sformatf("vec%0d_u%0d_idle", i, u), {in_ready[u], out_valid[u], busy[u]}, 3'b100);
      end

    // Exhaustive LUT sweep: 16 blocks cover 0x00..0xFF
    for (int u = 0; u < NU; u += 2)
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * j + k);
        run_block(u, d, 1'b0, 1'b0, q, lat);
        check($sformatf("sweep%0d_u%0d_data", j, u), q, inv_block(d));
        check($sformatf("sweep%0d_u%0d_lat", j, u), lat, n_of(u));
      end

    // Backpressure on BPC=1: stall 10 cycles in DONE with in_valid pulsing
    d = rand128();
    exp = inv_block(d);
    in_data[0] = d; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 16);
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = (c % 2) == 0;
      in_data[0]  = ~d ^ 128'(c);
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {in_ready[0], out_valid[0], busy[0], out_data[0]}, {3'b010, exp});
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_release", {in_ready[0], out_valid[0], busy[0]}, 3'b100);

    // Reset in the middle of RUN on BPC=1
    d = rand128();
    in_data[0] = d; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset", {in_ready[0], out_valid[0], busy[0], out_data[0]}, {3'b100, 128'h0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    check("mid_no_valid", seen, 1'b0);
    d2 = rand128();
    run_block(0, d2, 1'b0, 1'b0, q, lat);
    check("mid_after_data", q, inv_block(d2));
    check("mid_after_lat", lat, 16);

    // Random blocks on random instances
    for (int i = 0; i < 12; i++) begin
      int u;
      u = int'($urandom_range(0, NU - 1));
      d = rand128();
      run_block(u, d, 1'b0, 1'($urandom_range(0, 1)), q, lat);
      check($sformatf("rnd%0d_u%0d_data", i, u), q, inv_block(d));
      check($sformatf("rnd%0d_u%0d_lat", i, u), lat, n_of(u));
    end

`ifdef INVSUB_FWD_MODE_EN
    // Forward then inverse on BPC=4 recovers the original block
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      run_block(1, d, 1'b1, 1'b0, q, lat);
      check($sformatf("rt%0d_fwd", i), q, fwd_block(d));
      check($sformatf("rt%0d_fwd_lat", i), lat, 4);
      run_block(1, q, 1'b0, 1'b0, d2, lat);
      check($sformatf("rt%0d_inv", i), d2, d);
      check($sformatf("rt%0d_inv_lat", i), lat, 4);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
